// File: rtl/bmd64_rwdma_fsm_pkg.sv
// Shared types and helpers for the BMD64 write-DMA sequencer.
package bmd64_rwdma_fsm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_GAP
    } rwdma_state_t;

    localparam int ST_RUNNING = 0;
    localparam int ST_PENDING = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_TIMEOUT = 3;

    localparam int CC_TIMEOUT_DEFAULT = 20000;

    // Bytes moved by one block: DWORDs per TLP x TLPs per block x 4.
    function automatic logic [39:0] block_bytes(
        input logic [9:0]  len,
        input logic [15:0] cnt
    );
        logic [25:0] prod;
        prod = {16'b0, len} * {10'b0, cnt};
        return {12'b0, prod, 2'b00};
    endfunction

endpackage

// File: rtl/bmd64_rwdma_fsm_cc_watchdog.sv
// Timeframe watchdog: counts running cycles between timeframe-end strobes.
module rwdma_cc_watchdog
    import bmd64_rwdma_fsm_pkg::*;
#(
    parameter int LIMIT = CC_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic tick,
    output logic timeout
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] CMAX = W'(LIMIT);

    logic [W-1:0] cnt_q;

    // Saturates at the limit so the flag holds until a strobe or idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr || tick || !run) begin
            cnt_q <= '0;
        end else if (cnt_q != CMAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (cnt_q == CMAX);

endmodule

// File: rtl/bmd64_rwdma_fsm.sv
// Write-DMA sequencer: walks host buffers block by block for the TLP engine.
module bmd64_rwdma_fsm
    import bmd64_rwdma_fsm_pkg::*;
#(
    parameter int CC_TIMEOUT_CYCLES = CC_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_rst_i,
    input  logic [9:0]  mwr_len_i,
    input  logic [15:0] mwr_count_i,
    input  logic [15:0] wdma_frame_len_i,
    input  logic [31:0] next_wdma_addr_i,
    input  logic [7:0]  next_wdma_up_addr_i,
    input  logic        next_wdma_valid_i,
    input  logic        wdma_start_i,
    input  logic        wdma_stop_i,
    input  logic        wdma_done_i,
    input  logic        timeframe_end_rise_i,
    output logic        wdma_start_o,
    output logic [39:0] wdma_addr_o,
    output logic        wdma_rst_o,
    output logic        wdma_irq_o,
    output logic        wdma_running_o,
    output logic [15:0] wdma_buf_ptr_o,
    output logic [3:0]  wdma_status_o,
    output logic        cc_timeout_o
);

    rwdma_state_t state_q, state_d;

    logic [39:0] addr_q, addr_d;
    logic [39:0] pend_addr_q, pend_addr_d;
    logic [15:0] ptr_q, ptr_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic        stop_q, stop_d;
    logic        end_q, end_d;
    logic        start_q, start_d;
    logic        irq_q, irq_d;

    logic [39:0] next_addr;
    logic [15:0] frame_eff;
    logic [16:0] ptr_inc;
    logic        wrap;
    logic        running;

    assign next_addr = {next_wdma_up_addr_i, next_wdma_addr_i};
    assign frame_eff = (wdma_frame_len_i == 16'd0) ? 16'd1 : wdma_frame_len_i;
    assign ptr_inc   = {1'b0, ptr_q} + 17'd1;
    assign wrap      = (ptr_inc >= {1'b0, frame_eff});
    assign running   = (state_q != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pend_addr_q <= '0;
            ptr_q       <= '0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            stop_q      <= 1'b0;
            end_q       <= 1'b0;
            start_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pend_addr_q <= pend_addr_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            stop_q      <= stop_d;
            end_q       <= end_d;
            start_q     <= start_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pend_addr_d = pend_addr_q;
        ptr_d       = ptr_q;
        pend_d      = pend_q;
        ovr_d       = ovr_q;
        stop_d      = stop_q;
        end_d       = end_q;
        start_d     = start_q;
        irq_d       = 1'b0;

        if (next_wdma_valid_i) begin
            pend_addr_d = next_addr;
            pend_d      = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (wdma_start_i && pend_q) begin
                    addr_d  = pend_addr_q;
                    pend_d  = next_wdma_valid_i;
                    ovr_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                stop_d  = stop_q | wdma_stop_i;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                stop_d = stop_q | wdma_stop_i;
                if (wdma_done_i) begin
                    start_d = 1'b0;
                    state_d = S_DONE;
                    addr_d  = addr_q + block_bytes(mwr_len_i, mwr_count_i);
                    ptr_d   = ptr_inc[15:0];
                    if (wrap) begin
                        ptr_d = '0;
                        irq_d = 1'b1;
                        // A same-cycle host address wins over the pending one.
                        if (next_wdma_valid_i) begin
                            addr_d = next_addr;
                            pend_d = 1'b0;
                        end else if (pend_q) begin
                            addr_d = pend_addr_q;
                            pend_d = 1'b0;
                        end else begin
                            ovr_d = 1'b1;
                            end_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                end_d  = 1'b0;
                stop_d = 1'b0;
                if (end_q || stop_q || wdma_stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = wdma_stop_i ? S_IDLE : S_START;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (init_rst_i) begin
            state_d     = S_IDLE;
            addr_d      = '0;
            pend_addr_d = '0;
            ptr_d       = '0;
            pend_d      = 1'b0;
            ovr_d       = 1'b0;
            stop_d      = 1'b0;
            end_d       = 1'b0;
            start_d     = 1'b0;
            irq_d       = 1'b0;
        end
    end

    rwdma_cc_watchdog #(
        .LIMIT(CC_TIMEOUT_CYCLES)
    ) u_cc_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (init_rst_i),
        .run    (running),
        .tick   (timeframe_end_rise_i),
        .timeout(cc_timeout_o)
    );

    assign wdma_start_o   = start_q;
    assign wdma_addr_o    = addr_q;
    assign wdma_rst_o     = (state_q == S_DONE);
    assign wdma_irq_o     = irq_q;
    assign wdma_running_o = running;
    assign wdma_buf_ptr_o = ptr_q;

    always_comb begin
        wdma_status_o             = '0;
        wdma_status_o[ST_RUNNING] = running;
        wdma_status_o[ST_PENDING] = pend_q;
        wdma_status_o[ST_OVERRUN] = ovr_q;
        wdma_status_o[ST_TIMEOUT] = cc_timeout_o;
    end

endmodule

// File: tb/tb_bmd64_rwdma_fsm.sv
// Bench for bmd64_rwdma_fsm: cycle model plus directed scenarios.
module tb_bmd64_rwdma_fsm;

    localparam int LIMIT = 20000;
    localparam int W_START = 0;
    localparam int W_RST = 1;
    localparam int W_IDLE = 2;
    localparam int W_TO = 3;
    localparam int P_START = 0;
    localparam int P_STOP = 1;
    localparam int P_TFE = 2;
    localparam int P_INIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_rst_i = 1'b0;
    logic [9:0]  mwr_len_i = '0;
    logic [15:0] mwr_count_i = '0;
    logic [15:0] wdma_frame_len_i = '0;
    logic [31:0] next_wdma_addr_i = '0;
    logic [7:0]  next_wdma_up_addr_i = '0;
    logic        next_wdma_valid_i = 1'b0;
    logic        wdma_start_i = 1'b0;
    logic        wdma_stop_i = 1'b0;
    logic        wdma_done_i = 1'b0;
    logic        timeframe_end_rise_i = 1'b0;
    logic        wdma_start_o;
    logic [39:0] wdma_addr_o;
    logic        wdma_rst_o;
    logic        wdma_irq_o;
    logic        wdma_running_o;
    logic [15:0] wdma_buf_ptr_o;
    logic [3:0]  wdma_status_o;
    logic        cc_timeout_o;

    always #5 clk = ~clk;

    bmd64_rwdma_fsm #(
        .CC_TIMEOUT_CYCLES(LIMIT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_rst_i          (init_rst_i),
        .mwr_len_i           (mwr_len_i),
        .mwr_count_i         (mwr_count_i),
        .wdma_frame_len_i    (wdma_frame_len_i),
        .next_wdma_addr_i    (next_wdma_addr_i),
        .next_wdma_up_addr_i (next_wdma_up_addr_i),
        .next_wdma_valid_i   (next_wdma_valid_i),
        .wdma_start_i        (wdma_start_i),
        .wdma_stop_i         (wdma_stop_i),
        .wdma_done_i         (wdma_done_i),
        .timeframe_end_rise_i(timeframe_end_rise_i),
        .wdma_start_o        (wdma_start_o),
        .wdma_addr_o         (wdma_addr_o),
        .wdma_rst_o          (wdma_rst_o),
        .wdma_irq_o          (wdma_irq_o),
        .wdma_running_o      (wdma_running_o),
        .wdma_buf_ptr_o      (wdma_buf_ptr_o),
        .wdma_status_o       (wdma_status_o),
        .cc_timeout_o        (cc_timeout_o)
    );

    int errors = 0;
    int checks = 0;
    int lat = 1000;
    int eng_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Engine stand-in: done rises lat cycles into a block, drops on wdma_rst_o.
    always @(negedge clk) begin
        if (rst || init_rst_i || wdma_rst_o) begin
            wdma_done_i = 1'b0;
            eng_cnt = 0;
        end else if (wdma_start_o && !wdma_done_i) begin
            eng_cnt++;
            if (eng_cnt >= lat) wdma_done_i = 1'b1;
        end
    end

    // Behavioural model. m_lead counts edges left until the engine start
    // rises; m_rst marks the one block-complete cycle.
    longint unsigned m_addr = 0;
    longint unsigned m_pend_addr = 0;
    int m_ptr = 0;
    int m_lead = 0;
    int m_wd = 0;
    bit m_pend = 0, m_ovr = 0, m_run = 0, m_start = 0;
    bit m_rst = 0, m_irq = 0, m_stop = 0, m_end = 0;

    always @(posedge clk) begin
        longint unsigned blk, loadv;
        int fl;
        bit load, was_rst;
        if (rst || init_rst_i) begin
            m_addr = 0; m_pend_addr = 0; m_ptr = 0; m_lead = 0; m_wd = 0;
            m_pend = 0; m_ovr = 0; m_run = 0; m_start = 0;
            m_rst = 0; m_irq = 0; m_stop = 0; m_end = 0;
        end else begin
            if (!m_run || timeframe_end_rise_i) m_wd = 0;
            else if (m_wd < LIMIT) m_wd++;
            blk = mwr_len_i;
            blk = blk * mwr_count_i * 4;
            fl = (wdma_frame_len_i == 0) ? 1 : int'(wdma_frame_len_i);
            load = next_wdma_valid_i;
            loadv = {24'b0, next_wdma_up_addr_i, next_wdma_addr_i};
            was_rst = m_rst;
            m_rst = 0;
            m_irq = 0;
            if (!m_run) begin
                if (wdma_start_i && m_pend) begin
                    m_run = 1; m_addr = m_pend_addr; m_pend = 0;
                    m_ovr = 0; m_lead = 1; m_stop = 0;
                end
            end else if (was_rst) begin
                if (m_end || m_stop || wdma_stop_i) begin
                    m_run = 0; m_end = 0; m_stop = 0;
                end else begin
                    m_lead = 2;
                end
            end else if (m_start) begin
                if (wdma_stop_i) m_stop = 1;
                if (wdma_done_i) begin
                    m_start = 0;
                    m_rst = 1;
                    m_ptr++;
                    if (m_ptr >= fl) begin
                        m_ptr = 0;
                        m_irq = 1;
                        if (load) begin
                            m_addr = loadv; load = 0; m_pend = 0;
                        end else if (m_pend) begin
                            m_addr = m_pend_addr; m_pend = 0;
                        end else begin
                            m_ovr = 1; m_end = 1;
                            m_addr = (m_addr + blk) & 64'hFF_FFFF_FFFF;
                        end
                    end else begin
                        m_addr = (m_addr + blk) & 64'hFF_FFFF_FFFF;
                    end
                end
            end else begin
                if (m_lead == 2 && wdma_stop_i) begin
                    m_run = 0; m_lead = 0;
                end else begin
                    if (wdma_stop_i) m_stop = 1;
                    m_lead--;
                    if (m_lead == 0) m_start = 1;
                end
            end
            if (load) begin
                m_pend = 1; m_pend_addr = loadv;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] mst;
        logic [15:0] mp;
        mst = {m_wd >= LIMIT, m_ovr, m_pend, m_run};
        mp = 16'(m_ptr);
        chk("cyc_ctl",
            64'({wdma_start_o, wdma_rst_o, wdma_irq_o, wdma_running_o,
                 cc_timeout_o, wdma_status_o, wdma_buf_ptr_o}),
            64'({m_start, m_rst, m_irq, m_run, m_wd >= LIMIT, mst, mp}));
        chk("cyc_addr", 64'(wdma_addr_o), 64'(m_addr[39:0]));
    end

    task automatic wait_sig(input int which, input int maxc, output bit ok, output int n);
        ok = 0;
        n = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            n++;
            case (which)
                W_START: ok = wdma_start_o;
                W_RST:   ok = wdma_rst_o;
                W_IDLE:  ok = !wdma_running_o;
                default: ok = cc_timeout_o;
            endcase
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        case (which)
            P_START: wdma_start_i = 1'b1;
            P_STOP:  wdma_stop_i = 1'b1;
            P_TFE:   timeframe_end_rise_i = 1'b1;
            default: init_rst_i = 1'b1;
        endcase
        @(negedge clk);
        wdma_start_i = 1'b0;
        wdma_stop_i = 1'b0;
        timeframe_end_rise_i = 1'b0;
        init_rst_i = 1'b0;
    endtask

    task automatic load(input logic [7:0] up, input logic [31:0] lo);
        @(negedge clk);
        next_wdma_up_addr_i = up;
        next_wdma_addr_i = lo;
        next_wdma_valid_i = 1'b1;
        @(negedge clk);
        next_wdma_valid_i = 1'b0;
    endtask

    initial begin
        bit ok;
        int n;
        logic [3:0] st;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_start", 64'(wdma_start_o), 64'd0);
        chk("rst_running", 64'(wdma_running_o), 64'd0);
        chk("rst_status", 64'(wdma_status_o), 64'd0);
        chk("rst_addr", 64'(wdma_addr_o), 64'd0);
        rst = 1'b0;
        mwr_len_i = 10'd32;
        mwr_count_i = 16'd16;
        wdma_frame_len_i = 16'd2;

        load(8'h00, 32'h8000_0000);
        st = wdma_status_o;
        chk("t1_pending", 64'(st[1]), 64'd1);
        pulse(P_START);
        wait_sig(W_START, 5, ok, n);
        chk("t1_start_seen", 64'(ok), 64'd1);
        chk("t1_start_lat", 64'(n), 64'd1);
        chk("t1_addr0", 64'(wdma_addr_o), 64'h80_0000_0000 >> 8);
        chk("t1_ptr0", 64'(wdma_buf_ptr_o), 64'd0);
        wait_sig(W_RST, 1100, ok, n);
        chk("t1_rst1", 64'(ok), 64'd1);
        chk("t1_ptr1", 64'(wdma_buf_ptr_o), 64'd1);
        chk("t1_irq_n", 64'(wdma_irq_o), 64'd0);
        chk("t1_start_fall", 64'(wdma_start_o), 64'd0);
        wait_sig(W_START, 5, ok, n);
        chk("t1_restart_lat", 64'(n), 64'd3);
        chk("t1_addr1", 64'(wdma_addr_o), 64'h8000_0800);
        wait_sig(W_RST, 1100, ok, n);
        chk("t1_rst2", 64'(ok), 64'd1);
        chk("t1_irq", 64'(wdma_irq_o), 64'd1);
        chk("t1_ptr_wrap", 64'(wdma_buf_ptr_o), 64'd0);
        st = wdma_status_o;
        chk("t1_overrun", 64'(st[2]), 64'd1);
        wait_sig(W_IDLE, 5, ok, n);
        chk("t1_idle", 64'(ok), 64'd1);

        load(8'h00, 32'h8000_0000);
        pulse(P_START);
        wait_sig(W_START, 5, ok, n);
        st = wdma_status_o;
        chk("t2_ovr_clr", 64'(st[2]), 64'd0);
        load(8'h01, 32'h0000_0000);
        wait_sig(W_RST, 1100, ok, n);
        wait_sig(W_START, 5, ok, n);
        wait_sig(W_RST, 1100, ok, n);
        chk("t2_irq", 64'(wdma_irq_o), 64'd1);
        st = wdma_status_o;
        chk("t2_no_ovr", 64'(st[2]), 64'd0);
        chk("t2_pend_used", 64'(st[1]), 64'd0);
        wait_sig(W_START, 5, ok, n);
        chk("t2_addr2", 64'(wdma_addr_o), 64'h1_0000_0000);
        pulse(P_STOP);
        wait_sig(W_RST, 1100, ok, n);
        chk("t4_stop_rst", 64'(ok), 64'd1);
        chk("t4_stop_ptr", 64'(wdma_buf_ptr_o), 64'd1);
        wait_sig(W_IDLE, 3, ok, n);
        chk("t4_stop_idle", 64'(ok), 64'd1);
        wait_sig(W_START, 10, ok, n);
        chk("t4_no_restart", 64'(ok), 64'd0);

        pulse(P_START);
        wait_sig(W_START, 10, ok, n);
        chk("t3_nopend_start", 64'(ok), 64'd0);
        chk("t3_nopend_run", 64'(wdma_running_o), 64'd0);

        lat = 1000000;
        load(8'h00, 32'h0000_4000);
        pulse(P_START);
        wait_sig(W_TO, LIMIT + 50, ok, n);
        chk("t5_timeout", 64'(ok), 64'd1);
        st = wdma_status_o;
        chk("t5_status_to", 64'(st[3]), 64'd1);
        pulse(P_TFE);
        st = wdma_status_o;
        chk("t5_to_clr", 64'(cc_timeout_o), 64'd0);
        chk("t5_status_clr", 64'(st[3]), 64'd0);

        load(8'h00, 32'h0000_8000);
        pulse(P_INIT);
        chk("t6_start", 64'(wdma_start_o), 64'd0);
        chk("t6_running", 64'(wdma_running_o), 64'd0);
        chk("t6_status", 64'(wdma_status_o), 64'd0);
        chk("t6_addr", 64'(wdma_addr_o), 64'd0);
        chk("t6_misc", 64'({wdma_rst_o, wdma_irq_o, cc_timeout_o, wdma_buf_ptr_o}), 64'd0);
        lat = 1000;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bmd64_rwdma_fsm.md
# bmd64_rwdma_fsm

Write-DMA sequencing controller for the 64-bit bus-master DMA (BMD) path of the PCIe sniffer. It holds the host-programmed 40-bit buffer address and arms on a host start command. It then drives the write-DMA engine one block at a time, advancing the address and buffer pointer after each completed block. After `wdma_frame_len_i` blocks it raises an interrupt and switches to the next host-supplied buffer. It sits between the host register file (PIO target) and the TLP write-DMA engine.

## Interface
- `CC_TIMEOUT_CYCLES`, default 20000: clock cycles without a `timeframe_end_rise_i` pulse, while running, before `cc_timeout_o` asserts.

Ports:
- `clk`  in  1  single clock; every signal is in this domain.
- `rst`  in  1  asynchronous, active-high reset.
- `init_rst_i`  in  1  synchronous soft reset; same effect as `rst`; highest priority.
- `mwr_len_i`  in  10  DWORDs per write TLP.
- `mwr_count_i`  in  16  TLPs per block.
- `wdma_frame_len_i`  in  16  blocks per buffer; 0 is treated as 1.
- `next_wdma_addr_i`  in  32  next buffer address, low 32 bits.
- `next_wdma_up_addr_i`  in  8  next buffer address, bits 39:32.
- `next_wdma_valid_i`  in  1  one-cycle strobe that loads the pending address.
- `wdma_start_i`  in  1  one-cycle strobe: host start.
- `wdma_stop_i`  in  1  one-cycle strobe: host stop.
- `wdma_done_i`  in  1  engine block-complete level; held until `wdma_rst_o`.
- `timeframe_end_rise_i`  in  1  one-cycle timeframe-end strobe.
- `wdma_start_o`  out  1  engine start level, held for the whole block.
- `wdma_addr_o`  out  40  block start address; stable while `wdma_start_o` is high.
- `wdma_rst_o`  out  1  one-cycle engine reset after each block.
- `wdma_irq_o`  out  1  one-cycle buffer-complete interrupt.
- `wdma_running_o`  out  1  controller is not idle.
- `wdma_buf_ptr_o`  out  16  blocks completed in the current buffer.
- `wdma_status_o`  out  4  status bits: [0] running, [1] address pending, [2] overrun (sticky), [3] cc_timeout.
- `cc_timeout_o`  out  1  timeframe watchdog expired.

## Operation
- Pending address register: `next_wdma_valid_i` loads {up_addr, addr} and sets the pending flag.
- States:
  - IDLE: if `wdma_start_i` is high and the pending flag is set, copy pending to the current address, clear pending, clear overrun, and go to START. If pending is clear, the start is ignored.
  - START: set `wdma_start_o`, go to BUSY.
  - BUSY: wait for `wdma_done_i`, then go to DONE.
  - DONE: `wdma_start_o`=0 and `wdma_rst_o`=1 for this one cycle.
    - addr += `mwr_len_i`·`mwr_count_i`·4, computed modulo 2^40.
    - buf_ptr += 1.
    - If buf_ptr reaches the frame length: `wdma_irq_o`=1 and buf_ptr=0. If pending is set, consume it; otherwise set overrun and go to IDLE.
    - If a stop was latched, go to IDLE; otherwise go to GAP.
  - GAP: one idle cycle, then START.
- `wdma_stop_i` in START or BUSY is latched; the current block finishes first, then the FSM goes to IDLE. In GAP it goes to IDLE immediately. In IDLE it has no effect.
- If `next_wdma_valid_i` arrives in the same cycle as a buffer switch, the incoming value is used directly and pending stays clear.
- Watchdog: a counter runs while running and is cleared by `timeframe_end_rise_i`. At `CC_TIMEOUT_CYCLES` it asserts `cc_timeout_o` and holds it until the next strobe or until idle.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- `wdma_start_o` rises 2 cycles after the `wdma_start_i` edge (IDLE→START→BUSY, registered).
- `wdma_done_i` sampled high at edge N: `wdma_rst_o` is high in cycle N+1 and `wdma_start_o` falls in that same cycle.
- The address and buf_ptr update in the same cycle as `wdma_rst_o`.
- The next `wdma_start_o` rise follows 2 cycles after the `wdma_rst_o` cycle.
- `wdma_irq_o` is coincident with the `wdma_rst_o` of the final block.
- `init_rst_i` or `rst` mid-block: IDLE immediately, `wdma_start_o` drops, and the pending flag clears.

## Structure
- A shared package holds the state enum (IDLE, START, BUSY, DONE, GAP) and the status bit indices.
- One sub-module, `rwdma_cc_watchdog`, holds the timeout counter.

## Test plan
- Load 0x80000000, start, done returned 1000 cycles after each start, frame_len=2, len=32, count=16 → blocks at 0x80000000 then 0x80000800. `wdma_irq_o` pulses with the second `wdma_rst_o`; buf_ptr goes 0→1→0; overrun is set; FSM returns to IDLE.
- Same setup with a second address 0x1_00000000 loaded mid-buffer → third block at 0x1_00000000 with no overrun.
- Start with nothing pending → `wdma_start_o` stays 0 and `wdma_running_o` stays 0.
- Stop during BUSY → block completes, `wdma_rst_o` pulses, no further start, running falls.
- No `timeframe_end_rise_i` for 20000 running cycles → `cc_timeout_o`=1 and status[3]=1. One strobe clears both.
- `init_rst_i` mid-block → all outputs return to 0 on the next cycle.
